// File: rtl/uart_num_tx.sv
// uart_num_tx: turns a binary value into an ASCII number string (decimal or
// uppercase hex) and hands it to uart_tx one byte at a time. Leading zeros
// can be suppressed (the last digit is always sent) and CR/LF can be appended.
//
// Ports:
//   mclk      - system clock
//   reset     - synchronous, active-high reset
//   start     - one-cycle request; value sampled on the same edge
//   value     - binary number to print (WIDTH bits)
//   busy      - high from the cycle after an accepted start until done
//   done      - one-cycle pulse after the last character is accepted
//   overflow  - captured with start: value does not fit in DIGITS digits
//   tx_data   - byte to uart_tx data
//   tx_strobe - one-cycle pulse to uart_tx data_strobe
//   tx_ready  - uart_tx ready
module uart_num_tx #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int HEX         = 0,
    parameter int LZ_SUPPRESS = 1,
    parameter int EOL         = 1
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [7:0]       tx_data,
    output logic             tx_strobe,
    input  logic             tx_ready
);

    localparam int DW = DIGITS * 4;
    localparam int EW = (WIDTH > DW) ? WIDTH : DW;
    localparam int LW = (WIDTH > DW + 1) ? WIDTH : DW + 1;
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, CONVERT, LOAD, SEND, WAIT_BUSY, WAIT_DONE, FINISH
    } state_t;

    typedef enum logic [1:0] {PH_DIG, PH_CR, PH_LF} phase_t;

    // Smallest value that no longer fits: 10^DIGITS or 16^DIGITS.
    function automatic logic [LW-1:0] calc_limit();
        logic [LW-1:0] r;
        r = LW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r = r * LW'((HEX != 0) ? 16 : 10);
        end
        return r;
    endfunction

    localparam logic [LW-1:0] LIMIT = calc_limit();

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        data_q, data_d;
    logic              strobe_q, strobe_d;

    logic [EW-1:0]     value_ext;
    logic [DW-1:0]     adj;
    logic [PW-1:0]     lead;
    logic [3:0]        cur_digit;
    logic [7:0]        cur_char;
    logic              last;

    assign value_ext = EW'(value);
    assign cur_digit = dig_q[{ptr_q, 2'b00} +: 4];

    always_comb begin
        cur_char = 8'h0D;
        case (phase_q)
            PH_DIG:  cur_char = (cur_digit < 4'd10) ? (8'h30 + {4'h0, cur_digit})
                                                    : (8'h37 + {4'h0, cur_digit});
            PH_CR:   cur_char = 8'h0D;
            PH_LF:   cur_char = 8'h0A;
            default: cur_char = 8'h0D;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        dig_d    = dig_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        adj      = dig_q;
        lead     = '0;
        last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d   = (LW'(value) >= LIMIT);
                    busy_d  = 1'b1;
                    phase_d = PH_DIG;
                    cnt_d   = '0;
                    if (HEX != 0) begin
                        dig_d   = value_ext[DW-1:0];
                        state_d = LOAD;
                    end else begin
                        dig_d   = '0;
                        sh_d    = value;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                // Double-dabble step: correct every BCD digit >= 5, then shift
                // in the next value bit. Carries out of the top digit are lost,
                // which leaves value mod 10^DIGITS.
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (dig_q[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
                    end
                end
                dig_d = {adj[DW-2:0], sh_q[WIDTH-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Ascending scan leaves the highest non-zero digit; all-zero
                // gives index 0 so the final '0' is still printed.
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (dig_q[4*i +: 4] != 4'd0) begin
                        lead = PW'(i);
                    end
                end
                ptr_d   = (LZ_SUPPRESS != 0) ? lead : PW'(DIGITS - 1);
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    data_d   = cur_char;
                    strobe_d = 1'b1;
                    state_d  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = SEND;
                    case (phase_q)
                        PH_DIG: begin
                            if (ptr_q != '0) begin
                                ptr_d = ptr_q - PW'(1);
                            end else if (EOL != 0) begin
                                phase_d = PH_CR;
                            end else begin
                                last = 1'b1;
                            end
                        end
                        PH_CR:   phase_d = PH_LF;
                        default: last = 1'b1;
                    endcase
                    if (last) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= PH_DIG;
            dig_q    <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            dig_q    <= dig_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign tx_data   = data_q;
    assign tx_strobe = strobe_q;

endmodule

// File: tb/tb_uart_num_tx.sv
// Directed bench for uart_num_tx: four configurations, each with a simple
// uart_tx ready model, byte capture and strobe-rule monitoring.
module tb_uart_num_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  force_low;
    logic [15:0] value [4];
    wire  [3:0]  busy, done, ovf, strobe;
    wire  [7:0]  tx_data [4];
    logic [3:0]  ready = 4'hF;

    logic [7:0]  cap [4][32];
    int          cap_cyc [4][32];
    int          cap_n [4] = '{default: 0};
    int          done_cnt [4] = '{default: 0};
    int          rd_cnt [4] = '{default: 0};
    int          cyc = 0;
    logic [3:0]  prev_strobe = 4'h0;
    logic [3:0]  b2b = 4'h0;
    logic [3:0]  lowstb = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_num_tx #(.WIDTH(16), .DIGITS(5), .HEX(0), .LZ_SUPPRESS(1), .EOL(1)) u0 (
        .mclk(clk), .reset(rst), .start(start[0]), .value(value[0]), .busy(busy[0]),
        .done(done[0]), .overflow(ovf[0]), .tx_data(tx_data[0]), .tx_strobe(strobe[0]),
        .tx_ready(ready[0]));
    uart_num_tx #(.WIDTH(16), .DIGITS(5), .HEX(0), .LZ_SUPPRESS(0), .EOL(1)) u1 (
        .mclk(clk), .reset(rst), .start(start[1]), .value(value[1]), .busy(busy[1]),
        .done(done[1]), .overflow(ovf[1]), .tx_data(tx_data[1]), .tx_strobe(strobe[1]),
        .tx_ready(ready[1]));
    uart_num_tx #(.WIDTH(16), .DIGITS(4), .HEX(1), .LZ_SUPPRESS(1), .EOL(0)) u2 (
        .mclk(clk), .reset(rst), .start(start[2]), .value(value[2]), .busy(busy[2]),
        .done(done[2]), .overflow(ovf[2]), .tx_data(tx_data[2]), .tx_strobe(strobe[2]),
        .tx_ready(ready[2]));
    uart_num_tx #(.WIDTH(16), .DIGITS(3), .HEX(0), .LZ_SUPPRESS(1), .EOL(1)) u3 (
        .mclk(clk), .reset(rst), .start(start[3]), .value(value[3]), .busy(busy[3]),
        .done(done[3]), .overflow(ovf[3]), .tx_data(tx_data[3]), .tx_strobe(strobe[3]),
        .tx_ready(ready[3]));

    // uart_tx stand-in: ready drops on the edge a strobe is seen and returns
    // a few cycles later; force_low holds it low. Also captures bytes, the
    // edge each strobe rose on, done pulses and strobe-rule violations.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                if (cap_n[i] < 32) begin
                    cap[i][cap_n[i]]     <= tx_data[i];
                    cap_cyc[i][cap_n[i]] <= cyc - 1;
                end
                cap_n[i] <= cap_n[i] + 1;
                if (prev_strobe[i]) b2b[i] <= 1'b1;
                if (!ready[i]) lowstb[i] <= 1'b1;
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            prev_strobe[i] <= strobe[i];
            if (rst) begin
                ready[i]  <= 1'b1;
                rd_cnt[i] <= 0;
            end else if (force_low[i]) begin
                ready[i] <= 1'b0;
            end else if (!ready[i]) begin
                if (rd_cnt[i] == 0) ready[i] <= 1'b1;
                else rd_cnt[i] <= rd_cnt[i] - 1;
            end else if (strobe[i]) begin
                ready[i]  <= 1'b0;
                rd_cnt[i] <= 3;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag, input int i, input int base,
                             input logic [63:0] exp, input int n);
        chk({tag, "_count"}, cap_n[i] - base, n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), {24'h0, cap[i][base + k]},
                {24'h0, exp[(n - 1 - k) * 8 +: 8]});
        end
    endtask

    task automatic start_op(input int i, input logic [15:0] v,
                            output int scyc, output int base, output int dbase);
        base     = cap_n[i];
        dbase    = done_cnt[i];
        value[i] = v;
        start[i] = 1'b1;
        scyc     = cyc;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic finish_op(input int i, input int base, input int dbase, input int scyc,
                             input logic [63:0] exp, input int n, input logic ovf_exp,
                             input int lat, input string tag);
        int t;
        t = 0;
        while (done_cnt[i] == dbase && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, {31'h0, t < 3000}, 32'h1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt[i] - dbase, 1);
        chk({tag, "_busy_after"}, {31'h0, busy[i]}, 32'h0);
        chk({tag, "_overflow"}, {31'h0, ovf[i]}, {31'h0, ovf_exp});
        chk_bytes(tag, i, base, exp, n);
        if (lat >= 0) chk({tag, "_latency"}, cap_cyc[i][base] - scyc, lat);
    endtask

    task automatic run(input int i, input logic [15:0] v, input logic [63:0] exp,
                       input int n, input logic ovf_exp, input int lat, input string tag);
        int scyc, base, dbase;
        start_op(i, v, scyc, base, dbase);
        chk({tag, "_busy_next"}, {31'h0, busy[i]}, 32'h1);
        finish_op(i, base, dbase, scyc, exp, n, ovf_exp, lat, tag);
    endtask

    initial begin
        int scyc, base, dbase, t;
        rst       = 1'b1;
        start     = '0;
        force_low = '0;
        for (int i = 0; i < 4; i++) value[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {28'h0, busy}, 32'h0);
        chk("rst_done", {28'h0, done}, 32'h0);
        chk("rst_ovf", {28'h0, ovf}, 32'h0);
        chk("rst_strobe", {28'h0, strobe}, 32'h0);
        chk("rst_data", {24'h0, tx_data[0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run(0, 16'd1234, 64'h313233340D0A, 6, 1'b0, 18, "dec1234");
        run(0, 16'd0, 64'h300D0A, 3, 1'b0, 18, "dec0_lz");
        run(1, 16'd0, 64'h30303030300D0A, 7, 1'b0, 18, "dec0_nolz");
        run(2, 16'hBEEF, 64'h42454546, 4, 1'b0, 2, "hexbeef");
        run(3, 16'd1234, 64'h3233340D0A, 5, 1'b1, 18, "dig3_ovf");

        // Ready held low: nothing may be strobed; a second start is ignored.
        force_low[0] = 1'b1;
        repeat (2) @(negedge clk);
        start_op(0, 16'd56, scyc, base, dbase);
        repeat (50) @(negedge clk);
        chk("hold_no_strobe", cap_n[0] - base, 0);
        chk("hold_busy", {31'h0, busy[0]}, 32'h1);
        value[0] = 16'hFFFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        force_low[0] = 1'b0;
        finish_op(0, base, dbase, scyc, 64'h35360D0A, 4, 1'b0, -1, "hold56");

        // Reset while waiting for the second character to complete.
        start_op(0, 16'd1234, scyc, base, dbase);
        t = 0;
        while (cap_n[0] < base + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_timeout", {31'h0, t < 2000}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", {31'h0, busy[0]}, 32'h0);
        chk("rstmid_strobe", {31'h0, strobe[0]}, 32'h0);
        chk("rstmid_data", {24'h0, tx_data[0]}, 32'h0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstmid_no_more", cap_n[0] - base, 2);
        chk("rstmid_idle_busy", {31'h0, busy[0]}, 32'h0);
        run(0, 16'd7, 64'h370D0A, 3, 1'b0, 18, "after_rst7");

        chk("no_back_to_back", {28'h0, b2b}, 32'h0);
        chk("no_strobe_ready_low", {28'h0, lowstb}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
